// File: rtl/gf8_pkg.sv
// Shared definitions for the GF(2^8) matrix-vector controller: field polynomial,
// FSM encoding and matrix dimension.
package gf8_pkg;

  localparam logic [8:0] POLY_AES = 9'h11B;
  localparam int         DIM      = 4;
  localparam logic [1:0] LAST_IDX = 2'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/gf8_matvec_ctrl_if.sv
// Operand/command and result channels of the GF(2^8) 4x4 matrix-vector unit.
interface gf8_matvec_ctrl_if;

  // Handshakes: a transfer happens on a rising edge where valid (start / y_valid)
  // and ready (start_ready / y_ready) are both high; the offering side holds its
  // payload (mat_in/vec_in or y_data/y_row) stable until that edge.
  logic         start;
  logic         start_ready;
  logic [127:0] mat_in;
  logic [31:0]  vec_in;
  logic         abort;
  logic         y_valid;
  logic         y_ready;
  logic [7:0]   y_data;
  logic [1:0]   y_row;
  logic         done;

  modport master (
    output start, mat_in, vec_in, abort, y_ready,
    input  start_ready, y_valid, y_data, y_row, done
  );

  modport slave (
    input  start, mat_in, vec_in, abort, y_ready,
    output start_ready, y_valid, y_data, y_row, done
  );

endinterface

// File: rtl/GF8_Multiplier.sv
// Combinational 8x8 carry-less (polynomial over GF(2)) multiply, unreduced 16-bit product.
module GF8_Multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ ({8'h00, a} << i);
    end
  end

endmodule

// File: rtl/gf8_matvec_ctrl.sv
// Sequential GF(2^8) 4x4 matrix times 4-vector: one multiply-accumulate per cycle,
// each row reduced mod POLY and handed out over a valid/ready result channel.
module gf8_matvec_ctrl
  import gf8_pkg::*;
#(
  parameter logic [8:0] POLY = POLY_AES
) (
  input  logic              clk,
  input  logic              reset,
  gf8_matvec_ctrl_if.slave  bus,
  output state_t            state_dbg
);

  state_t       state;
  logic [1:0]   row, col;
  logic [14:0]  acc;
  logic [127:0] mat_q;
  logic [31:0]  vec_q;
  logic [7:0]   y_data_q;
  logic         y_valid_q, done_q;
  logic [15:0]  product;
  logic [14:0]  acc_next;
  logic         unused_product_msb;

  // Long division by POLY; bit 15 of an 8x8 product is always zero.
  function automatic logic [7:0] gf_reduce(input logic [14:0] x);
    logic [14:0] r;
    r = x;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (15'(POLY) << (i - 8));
    end
    return r[7:0];
  endfunction

  GF8_Multiplier u_mul (
    .a (mat_q[{row, col, 3'b000} +: 8]),
    .b (vec_q[{col, 3'b000} +: 8]),
    .p (product)
  );

  assign acc_next           = acc ^ product[14:0];
  assign unused_product_msb = product[15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      acc       <= '0;
      mat_q     <= '0;
      vec_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mat_q <= bus.mat_in;
            vec_q <= bus.vec_in;
            acc   <= '0;
            row   <= '0;
            col   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (col == LAST_IDX) begin
            y_data_q  <= gf_reduce(acc_next);
            y_valid_q <= 1'b1;
            state     <= EMIT;
          end else begin
            acc <= acc_next;
            col <= col + 2'd1;
          end
        end
        EMIT: begin
          // Abort wins over a handshake landing on the same edge.
          if (bus.abort) begin
            y_valid_q <= 1'b0;
            state     <= IDLE;
          end else if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            if (row == LAST_IDX) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              row   <= row + 2'd1;
              col   <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.y_valid     = y_valid_q;
  assign bus.y_data      = y_data_q;
  assign bus.y_row       = row;
  assign bus.done        = done_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_gf8_matvec_ctrl.sv
// Directed bench for gf8_matvec_ctrl: known GF(2^8) products, stall, abort and reset cases.
module tb_gf8_matvec_ctrl;
  import gf8_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     n_checks = 0;
  int     n_errors = 0;
  logic [7:0] exp_q[$];

  gf8_matvec_ctrl_if bus ();

  gf8_matvec_ctrl #(.POLY(9'h11B)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [127:0] M_IDENT = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] M_MIX   = 128'h02010103_03020101_01030201_01010302;
  localparam logic [127:0] M_57    = 128'h00000000_00000000_00000000_00000057;
  localparam logic [127:0] M_FF    = 128'hff000000_00000000_00000000_00000000;
  localparam logic [127:0] M_ONES  = {16{8'h01}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver + scoreboard for one full product. Entered and left at a falling edge;
  // on return the bench sits in the cycle where done is high.
  task automatic run_product(input logic [127:0] m, input logic [31:0] v, input logic [31:0] y,
                             input int stall_row, input int stall_len, input bit inject,
                             input string tag);
    int k, stalled, exp_row, done_k;
    bit seen_valid;
    exp_q.delete();
    for (int r = 0; r < 4; r++) exp_q.push_back(y[8*r +: 8]);
    bus.mat_in  = m;
    bus.vec_in  = v;
    bus.start   = 1'b1;
    bus.y_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0; stalled = 0; exp_row = 0; done_k = -1; seen_valid = 1'b0;
    while (done_k < 0 && k < 200) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy_sr"}, 32'(bus.start_ready), 32'd0);
      if (inject && k == 2) begin
        bus.mat_in = ~m;
        bus.vec_in = ~v;
        bus.start  = 1'b1;
      end else if (inject && k == 3) begin
        bus.start = 1'b0;
      end
      if (bus.y_valid) begin
        if (!seen_valid) begin
          check({tag, "_first_valid"}, 32'(k), 32'd4);
          seen_valid = 1'b1;
        end
        check({tag, "_row"}, 32'(bus.y_row), 32'(exp_row));
        if (exp_q.size() > 0) check({tag, "_data"}, 32'(bus.y_data), 32'(exp_q[0]));
        check({tag, "_done_vs_valid"}, 32'(bus.done), 32'd0);
        if (exp_row == stall_row && stalled < stall_len) begin
          bus.y_ready = 1'b0;
          check({tag, "_stall_state"}, 32'(state_dbg), 32'(EMIT));
          stalled++;
        end else begin
          bus.y_ready = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          exp_row++;
        end
      end
      if (bus.done) begin
        done_k = k;
        check({tag, "_done_sr"}, 32'(bus.start_ready), 32'd1);
      end
      k++;
    end
    check({tag, "_done_latency"}, 32'(done_k), 32'(20 + stall_len));
    check({tag, "_rows_left"}, 32'(exp_q.size()), 32'd0);
    bus.y_ready = 1'b1;
  endtask

  initial begin
    int  k;
    bit  done_seen;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.y_ready = 1'b1;
    bus.mat_in  = '0;
    bus.vec_in  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_y_data", 32'(bus.y_data), 32'd0);
    check("rst_y_row", 32'(bus.y_row), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    #1 check("rst_release_sr", 32'(bus.start_ready), 32'd1);
    @(negedge clk);

    // Back-to-back products: each new start lands in the previous done cycle
    run_product(M_IDENT, 32'h44332211, 32'h44332211, -1, 0, 1'b0, "ident");
    run_product(M_MIX,   32'h455313db, 32'hbca14d8e, -1, 0, 1'b0, "mix");
    run_product(M_57,    32'h00000083, 32'h000000c1, -1, 0, 1'b0, "m57");
    run_product(M_FF,    32'hff000000, 32'h13000000, -1, 0, 1'b0, "mff");
    run_product(M_ONES,  32'h12345678, 32'h08080808, -1, 0, 1'b0, "ones");
    run_product(M_MIX,   32'h455313db, 32'hbca14d8e, 1, 10, 1'b0, "stall");
    @(negedge clk);

    // Abort in IDLE is inert
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle_state", 32'(state_dbg), 32'(IDLE));

    // Abort in the third MAC cycle of row 2
    bus.mat_in = M_IDENT;
    bus.vec_in = 32'h44332211;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (13) @(negedge clk);
    check("abort_pre_state", 32'(state_dbg), 32'(MAC));
    check("abort_pre_row", 32'(bus.y_row), 32'd2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_y_valid", 32'(bus.y_valid), 32'd0);
    check("abort_sr", 32'(bus.start_ready), 32'd1);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    done_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done || bus.y_valid) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_product(M_MIX, 32'h455313db, 32'hbca14d8e, -1, 0, 1'b0, "post_abort");
    @(negedge clk);

    // Asynchronous reset while row 1 is being offered
    bus.mat_in = M_MIX;
    bus.vec_in = 32'h455313db;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    while (!(bus.y_valid && bus.y_row == 2'd1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached_row1", 32'(bus.y_row), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_mid_y_data", 32'(bus.y_data), 32'd0);
    check("rst_mid_y_row", 32'(bus.y_row), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_mid_release_sr", 32'(bus.start_ready), 32'd1);
    @(negedge clk);
    run_product(M_57, 32'h00000083, 32'h000000c1, -1, 0, 1'b1, "post_rst");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gf8_matvec_ctrl.md
GF8_MATVEC_CTRL -- requirements
Module: gf8_matvec_ctrl

Interface
REQ-001 Parameter POLY, default 9'h11B, field reduction polynomial for GF(2^8) (AES).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one 4x4-matrix by 4-vector product.
REQ-005 start_ready  output  1  high only in IDLE; start accepted when start && start_ready.
REQ-006 mat_in  input  128  matrix; element m[r][c] = mat_in[8*(4r+c) +: 8], sampled only on start accept.
REQ-007 vec_in  input  32  vector; element v[c] = vec_in[8c +: 8], sampled only on start accept.
REQ-008 abort  input  1  synchronous cancel of an in-progress product.
REQ-009 y_valid  output  1  result byte y_data is valid.
REQ-010 y_ready  input  1  consumer accepts y_data when y_valid && y_ready.
REQ-011 y_data  output  8  reduced result byte y[r] = XOR over c of m[r][c]*v[c] in GF(2^8).
REQ-012 y_row  output  2  row index r of y_data.
REQ-013 done  output  1  one-cycle pulse after row 3 is accepted.

Function
REQ-014 FSM states SHALL be IDLE, MAC, EMIT; counters row[1:0], col[1:0]; accumulator acc[14:0].
REQ-015 IDLE: on start accept, SHALL latch mat_in/vec_in, clear acc, row=0, col=0, go to MAC.
REQ-016 MAC: each cycle SHALL feed m[row][col] and v[col] to the multiplier and set acc ^= product[14:0], col++.
REQ-017 MAC with col==3: SHALL register y_data = (acc ^ product) mod POLY, go to EMIT; exactly 4 MAC cycles per row.
REQ-018 EMIT: y_valid=1, y_data/y_row held stable until handshake; y_ready low SHALL stall indefinitely without change.
REQ-019 EMIT handshake, row<3: row++, col=0, acc=0, return to MAC next cycle.
REQ-020 EMIT handshake, row==3: go to IDLE, assert done for exactly the next cycle.
REQ-021 Latency: start accepted at edge T -> MAC cycles T+1..T+4 -> y_valid from cycle T+5; with y_ready tied high a full product takes 20 cycles, done in cycle T+21.
REQ-022 Reduction SHALL be combinational polynomial long division of the 15-bit value by POLY, result 8 bits.
REQ-023 start while not IDLE SHALL be ignored, latched operands unchanged.
REQ-024 start in the cycle done is high (state IDLE) SHALL be accepted normally.
REQ-025 abort in MAC or EMIT SHALL return to IDLE next cycle, drop y_valid, no done pulse; abort in IDLE has no effect; abort has priority over a simultaneous y handshake.
REQ-026 y_valid SHALL never be high outside EMIT; done never high together with y_valid.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, row=0, col=0, acc=0, y_data=0, y_row=0, y_valid=0, done=0, latched operands=0.
REQ-028 reset mid-operation SHALL discard the product; after release, start_ready=1 on the first cycle.

Structure
REQ-029 Shared package gf8_pkg SHALL hold POLY default, FSM state enum, and DIM=4 constant.
REQ-030 Exactly one sub-module SHALL be instantiated: existing GF8_Multiplier (8x8 -> 16-bit carry-less product, combinational); reduction stays in this block.

Verification
REQ-031 Identity matrix (m[r][r]=01), vec_in=32'h44332211 -> y rows 0..3 = 11,22,33,44; done at T+21.
REQ-032 AES MixColumns matrix rows {02 03 01 01},{01 02 03 01},{01 01 02 03},{03 01 01 02}, v=(db,13,53,45) -> y=(8e,4d,a1,bc).
REQ-033 m[0][0]=57, all else 00, v[0]=83 -> y0=c1, y1..y3=00.
REQ-034 y_ready low 10 cycles on row 1 -> y_data/y_row held stable, no MAC progress, done delayed by 10 cycles.
REQ-035 abort in 3rd MAC cycle of row 2 -> y_valid 0, no done, start_ready=1 next cycle; new start yields correct full result.
REQ-036 reset low during EMIT row 1 -> all outputs 0 asynchronously; start after release yields correct result; start during MAC ignored.
